// File: rtl/rv32m_divide_pkg.sv
// Shared encodings for the RV32M divide unit: funct3 opcodes, FSM states and
// the architectural constants for the divide-by-zero and overflow fast paths.
package rv32m_divide_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOTIENT = 32'h8000_0000;
  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic [31:0] magnitude(input logic signed_op, input logic [31:0] v);
    return (signed_op && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/rv32m_divide_if.sv
// Decode-side request and ALU-side writeback signals of the divide unit.
interface rv32m_divide_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        cancel;
  logic        stall;
  logic        busy;
  logic        extm_update_rd;
  logic [4:0]  extm_rd_idx;
  logic [31:0] extm_rd_val;

  modport master (
    output start, funct3, a, b, rd_in, cancel,
    input  stall, busy, extm_update_rd, extm_rd_idx, extm_rd_val
  );

  modport slave (
    input  start, funct3, a, b, rd_in, cancel,
    output stall, busy, extm_update_rd, extm_rd_idx, extm_rd_val
  );
endinterface

// File: rtl/rv32m_divide_div_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one,
// trial-subtract the divisor, keep or restore, and shift in the quotient bit.
module rv32m_div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);
  logic [33:0] shifted;
  logic [34:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = {1'b0, shifted} - {3'b000, divisor_i};
    // diff[34] is the borrow: set means the trial subtraction went negative
    if (!diff[34]) begin
      rem_o = diff[32:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[32:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end
endmodule

// File: rtl/rv32m_divide.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2^k restoring divider with fast paths,
// stalling decode while it iterates and writing back through the ALU ext-M port.
module rv32m_divide
  import rv32m_divide_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  rv32m_divide_if.slave dif
);
  localparam int         N        = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(N - 1);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  idx_q, idx_d;

  logic        legal, signed_op, op_rem, accept, ovf;
  logic [31:0] quo_fin, rem_fin;
  logic [32:0] rem_chain [BITS_PER_CYCLE+1];
  logic [31:0] quo_chain [BITS_PER_CYCLE+1];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    rv32m_div_step u_step (
      .rem_i     (rem_chain[gi]),
      .quo_i     (quo_chain[gi]),
      .divisor_i (dvs_q),
      .rem_o     (rem_chain[gi+1]),
      .quo_o     (quo_chain[gi+1])
    );
  end

  always_comb begin
    legal     = dif.funct3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    signed_op = (dif.funct3 == F3_DIV) || (dif.funct3 == F3_REM);
    op_rem    = (dif.funct3 == F3_REM) || (dif.funct3 == F3_REMU);
    accept    = (state_q == ST_IDLE) && dif.start && legal &&
                (dif.rd_in != 5'd0) && !dif.cancel;
    ovf       = signed_op && (dif.a == OVF_DIVIDEND) && (dif.b == OVF_DIVISOR);
    quo_fin   = neg_quo_q ? 32'(-quo_chain[BITS_PER_CYCLE]) : quo_chain[BITS_PER_CYCLE];
    rem_fin   = neg_rem_q ? 32'(-rem_chain[BITS_PER_CYCLE][31:0])
                          : rem_chain[BITS_PER_CYCLE][31:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rd_d      = rd_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    idx_d     = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_d      = dif.rd_in;
          is_rem_d  = op_rem;
          neg_quo_d = signed_op && (dif.a[31] ^ dif.b[31]) && (dif.b != 32'd0);
          neg_rem_d = signed_op && dif.a[31];
          dvs_d     = magnitude(signed_op, dif.b);
          if (dif.b == 32'd0) begin
            res_d   = op_rem ? dif.a : DBZ_QUOTIENT;
            idx_d   = dif.rd_in;
            state_d = ST_DONE;
          end else if (ovf) begin
            res_d   = op_rem ? 32'd0 : OVF_QUOTIENT;
            idx_d   = dif.rd_in;
            state_d = ST_DONE;
          end else begin
            rem_d   = 33'd0;
            quo_d   = magnitude(signed_op, dif.a);
            cnt_d   = CNT_INIT;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = rem_chain[BITS_PER_CYCLE];
        quo_d = quo_chain[BITS_PER_CYCLE];
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          res_d   = is_rem_q ? rem_fin : quo_fin;
          idx_d   = rd_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An aborted operation must leave the previous writeback values untouched
    if (dif.cancel) begin
      state_d = ST_IDLE;
      res_d   = res_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      res_q   <= 32'd0;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    rd_q      <= rd_d;
    is_rem_q  <= is_rem_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign dif.stall          = accept || (state_q == ST_CALC);
  assign dif.busy           = (state_q != ST_IDLE);
  assign dif.extm_update_rd = (state_q == ST_DONE) && !dif.cancel;
  assign dif.extm_rd_idx    = idx_q;
  assign dif.extm_rd_val    = res_q;
endmodule

// File: tb/tb_rv32m_divide.sv
// Directed bench for rv32m_divide: one instance per BITS_PER_CYCLE setting,
// a vector table for single operations plus cancel/reset/NOP/held-start sequences.
module tb_rv32m_divide;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        sel2;
  logic        t_start, t_cancel;
  logic [2:0]  t_funct3;
  logic [31:0] t_a, t_b;
  logic [4:0]  t_rd;

  rv32m_divide_if dif1();
  rv32m_divide_if dif2();

  rv32m_divide #(.BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .dif(dif1));
  rv32m_divide #(.BITS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset(reset), .dif(dif2));

  assign dif1.start  = t_start & ~sel2;
  assign dif2.start  = t_start & sel2;
  assign dif1.funct3 = t_funct3;
  assign dif2.funct3 = t_funct3;
  assign dif1.a      = t_a;
  assign dif2.a      = t_a;
  assign dif1.b      = t_b;
  assign dif2.b      = t_b;
  assign dif1.rd_in  = t_rd;
  assign dif2.rd_in  = t_rd;
  assign dif1.cancel = t_cancel;
  assign dif2.cancel = t_cancel;

  logic        o_stall, o_busy, o_upd;
  logic [4:0]  o_idx;
  logic [31:0] o_val;
  assign o_stall = sel2 ? dif2.stall          : dif1.stall;
  assign o_busy  = sel2 ? dif2.busy           : dif1.busy;
  assign o_upd   = sel2 ? dif2.extm_update_rd : dif1.extm_update_rd;
  assign o_idx   = sel2 ? dif2.extm_rd_idx    : dif1.extm_rd_idx;
  assign o_val   = sel2 ? dif2.extm_rd_val    : dif1.extm_rd_val;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [20];

  // Issue one op at cycle T, then watch T..T+lat+4 for stall cycles and strobes.
  task automatic run_op(input string nm, input logic s, input logic [2:0] f3,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] rdv, input logic [31:0] expv, input int lat);
    int stall_cnt, strobe_cnt, strobe_at;
    logic [31:0] got_val;
    logic [4:0]  got_idx;
    stall_cnt = 0; strobe_cnt = 0; strobe_at = -1; got_val = '0; got_idx = '0;
    @(posedge clk); #1;
    sel2 = s; t_funct3 = f3; t_a = av; t_b = bv; t_rd = rdv; t_start = 1'b1;
    for (int i = 0; i <= lat + 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        t_start = 1'b0;
      end
      @(negedge clk);
      if (o_stall) stall_cnt++;
      if (o_upd) begin
        strobe_cnt++;
        strobe_at = i;
        got_val   = o_val;
        got_idx   = o_idx;
      end
    end
    chk({nm, ".strobes"}, 32'(strobe_cnt), 32'd1);
    chk({nm, ".latency"}, 32'(strobe_at), 32'(lat));
    chk({nm, ".val"}, got_val, expv);
    chk({nm, ".idx"}, {27'd0, got_idx}, {27'd0, rdv});
    chk({nm, ".stall_cycles"}, 32'(stall_cnt), 32'(lat));
  endtask

  initial begin
    int n_upd;
    vecs[0]  = '{1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 33};
    vecs[1]  = '{1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF, 33};
    vecs[2]  = '{1'b0, 3'b101, 32'hFFFF_FFFF, 32'd16,        5'd7,  32'h0FFF_FFFF, 33};
    vecs[3]  = '{1'b0, 3'b111, 32'hFFFF_FFFF, 32'd16,        5'd8,  32'd15,        33};
    vecs[4]  = '{1'b1, 3'b101, 32'hFFFF_FFFF, 32'd16,        5'd9,  32'h0FFF_FFFF, 17};
    vecs[5]  = '{1'b1, 3'b111, 32'hFFFF_FFFF, 32'd16,        5'd10, 32'd15,        17};
    vecs[6]  = '{1'b0, 3'b100, 32'd123,       32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{1'b0, 3'b111, 32'd123,       32'd0,         5'd12, 32'd123,       1};
    vecs[8]  = '{1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    vecs[9]  = '{1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1};
    vecs[10] = '{1'b0, 3'b100, 32'd100,       32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2, 33};
    vecs[11] = '{1'b0, 3'b110, 32'd100,       32'hFFFF_FFF9, 5'd16, 32'd2,         33};
    vecs[12] = '{1'b0, 3'b101, 32'd1000,      32'd3,         5'd17, 32'd333,       33};
    vecs[13] = '{1'b0, 3'b111, 32'd1000,      32'd3,         5'd18, 32'd1,         33};
    vecs[14] = '{1'b1, 3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd19, 32'd14,        17};
    vecs[15] = '{1'b1, 3'b110, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd20, 32'hFFFF_FFFE, 17};
    vecs[16] = '{1'b0, 3'b100, 32'h8000_0000, 32'd1,         5'd21, 32'h8000_0000, 33};
    vecs[17] = '{1'b0, 3'b110, 32'hFFFF_FFFB, 32'd0,         5'd22, 32'hFFFF_FFFB, 1};
    vecs[18] = '{1'b1, 3'b100, 32'd123,       32'd0,         5'd23, 32'hFFFF_FFFF, 1};
    vecs[19] = '{1'b1, 3'b101, 32'hDEAD_BEEF, 32'd16,        5'd24, 32'h0DEA_DBEE, 17};

    reset = 1'b1; sel2 = 1'b0; t_start = 1'b0; t_cancel = 1'b0;
    t_funct3 = 3'b000; t_a = '0; t_b = '0; t_rd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.stall", {31'd0, o_stall}, 32'd0);
    chk("rst.busy",  {31'd0, o_busy},  32'd0);
    chk("rst.upd",   {31'd0, o_upd},   32'd0);
    chk("rst.idx",   {27'd0, o_idx},   32'd0);
    chk("rst.val",   o_val,            32'd0);

    for (int v = 0; v < 20; v++)
      run_op($sformatf("vec%0d", v), vecs[v].sel, vecs[v].f3, vecs[v].a, vecs[v].b,
             vecs[v].rd, vecs[v].exp, vecs[v].lat);

    // NOP (rd 0) and illegal funct3 must neither stall nor write back
    @(posedge clk); #1;
    sel2 = 1'b0; t_funct3 = 3'b100; t_a = 32'd10; t_b = 32'd2; t_rd = 5'd0; t_start = 1'b1;
    @(negedge clk);
    chk("nop.stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    t_funct3 = 3'b000; t_rd = 5'd3;
    @(negedge clk);
    chk("illegal.stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    t_start = 1'b0;
    n_upd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_upd || o_busy) n_upd++;
      @(posedge clk); #1;
    end
    chk("nop.activity", 32'(n_upd), 32'd0);

    // Cancel at T+10: no strobe, idle at T+11, fresh op at T+12
    @(posedge clk); #1;
    sel2 = 1'b0; t_funct3 = 3'b100; t_a = 32'hFFFF_FFF9; t_b = 32'd2; t_rd = 5'd9; t_start = 1'b1;
    n_upd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      t_start = 1'b0;
      if (i == 10) t_cancel = 1'b1;
      @(negedge clk);
      if (o_upd) n_upd++;
    end
    @(posedge clk); #1;
    t_cancel = 1'b0;
    @(negedge clk);
    chk("cancel.busy",  {31'd0, o_busy},  32'd0);
    chk("cancel.stall", {31'd0, o_stall}, 32'd0);
    chk("cancel.no_strobe", 32'(n_upd + int'(o_upd)), 32'd0);
    run_op("after_cancel", 1'b0, 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd25, 32'hFFFF_FFF2, 33);

    // Reset at T+10: every output back to its reset value at T+11
    @(posedge clk); #1;
    sel2 = 1'b0; t_funct3 = 3'b101; t_a = 32'd1000; t_b = 32'd3; t_rd = 5'd26; t_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      t_start = 1'b0;
      if (i == 10) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst.stall", {31'd0, o_stall}, 32'd0);
    chk("midrst.busy",  {31'd0, o_busy},  32'd0);
    chk("midrst.upd",   {31'd0, o_upd},   32'd0);
    chk("midrst.idx",   {27'd0, o_idx},   32'd0);
    chk("midrst.val",   o_val,            32'd0);
    run_op("after_reset", 1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd27, 32'hFFFF_FFFF, 33);

    // start held high with different operands while busy must not disturb the result
    begin
      int strobe_at;
      logic [31:0] got_val;
      logic [4:0]  got_idx;
      strobe_at = -1; got_val = '0; got_idx = '0; n_upd = 0;
      @(posedge clk); #1;
      sel2 = 1'b0; t_funct3 = 3'b100; t_a = 32'hFFFF_FFF9; t_b = 32'd2; t_rd = 5'd5; t_start = 1'b1;
      for (int i = 1; i <= 38; i++) begin
        @(posedge clk); #1;
        if (i == 1) begin t_a = 32'd100; t_b = 32'd7; t_rd = 5'd6; end
        if (i == 33) t_start = 1'b0;
        @(negedge clk);
        if (o_upd) begin
          n_upd++; strobe_at = i; got_val = o_val; got_idx = o_idx;
        end
      end
      chk("held.strobes", 32'(n_upd), 32'd1);
      chk("held.latency", 32'(strobe_at), 32'd33);
      chk("held.val", got_val, 32'hFFFF_FFFD);
      chk("held.idx", {27'd0, got_idx}, 32'd5);
      chk("held.busy_end", {31'd0, o_busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
